dtfm_tx: RTL and testbench

- Transmit end of the DTFM serial link: generates dCLK, dFM and dDAT for the DTFM receiver.
- Takes 12-bit words over a valid/ready handshake and serializes them MSB first.
- Each frame: a dFM sync pulse, then SEGS segments of SEG_BITS data bits, with a GAP_CYC quiet gap before each segment. The gaps give the receiver time to insert its 44-bit markers.
- Used as a loopback/test source and as the data end of bench rigs.

---
 rtl/dtfm_tx.sv | 168 ++++++++++++++++
 tb/tb_dtfm_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dtfm_tx.sv
// dtfm_tx: transmit end of the DTFM serial link.
// Serializes 12-bit words MSB first into frames of SYNC, then SEGS x (GAP, SEG_BITS data bits).
// Words straddle gaps and back-to-back frames; any residue is dropped only on entry to IDLE.
module dtfm_tx #(
    parameter int CLK_DIV  = 4,
    parameter int SYNC_CYC = 8,
    parameter int GAP_CYC  = 160,
    parameter int SEG_BITS = 2816,
    parameter int SEGS     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iEn,
    input  logic [11:0] iData,
    input  logic        iValid,
    output logic        oReady,
    output logic        oDCLK,
    output logic        oDFM,
    output logic        oDAT,
    output logic        oUnderrun,
    output logic        oFrameStart,
    output logic        oBusy
);

    localparam int MAX_A   = (SYNC_CYC > GAP_CYC) ? SYNC_CYC : GAP_CYC;
    localparam int CNT_MAX = (MAX_A > 2 * CLK_DIV) ? MAX_A : 2 * CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(SEG_BITS + 1);
    localparam int SEG_W   = $clog2(SEGS + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] SEG_LAST  = BIT_W'(SEG_BITS - 1);
    localparam logic [SEG_W-1:0] FRM_LAST  = SEG_W'(SEGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_GAP,
        ST_DATA
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;     // cycle within SYNC, GAP or the current bit
    logic [BIT_W-1:0]   bit_q;     // bit index within the segment
    logic [SEG_W-1:0]   seg_q;     // segment index within the frame
    logic [11:0]        shift_q;   // remaining bits of the current word, MSB aligned
    logic [3:0]         wbits_q;   // bits of the current word still to send
    logic               dclk_q, dfm_q, dat_q, underrun_q, fstart_q, busy_q;

    logic               bit_start_nxt;
    logic               need_word;
    logic               load;
    logic [11:0]        word_d;

    // Decode whether the next cycle starts a bit and which word supplies it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        bit_start_nxt = 1'b0;
        word_d        = shift_q;
        if (state_q == ST_GAP && cnt_q == GAP_LAST)
            bit_start_nxt = 1'b1;
        if (state_q == ST_DATA && cnt_q == BIT_LAST && bit_q != SEG_LAST)
            bit_start_nxt = 1'b1;
        need_word = (wbits_q == 4'd0);
        load      = bit_start_nxt && need_word;
        if (need_word)
            word_d = iValid ? iData : 12'h000;
    end

    // Frame sequencer with registered serial outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            seg_q      <= '0;
            shift_q    <= '0;
            wbits_q    <= '0;
            dclk_q     <= 1'b0;
            dfm_q      <= 1'b0;
            dat_q      <= 1'b0;
            underrun_q <= 1'b0;
            fstart_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            fstart_q   <= 1'b0;
            underrun_q <= 1'b0;
            if (bit_start_nxt) begin
                state_q    <= ST_DATA;
                cnt_q      <= '0;
                dclk_q     <= 1'b1;
                dat_q      <= word_d[11];
                shift_q    <= {word_d[10:0], 1'b0};
                wbits_q    <= need_word ? 4'd11 : wbits_q - 4'd1;
                underrun_q <= load && !iValid;
                if (state_q == ST_DATA)
                    bit_q <= bit_q + BIT_W'(1);
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (iEn) begin
                            state_q  <= ST_SYNC;
                            cnt_q    <= '0;
                            dfm_q    <= 1'b1;
                            fstart_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                    ST_SYNC: begin
                        if (cnt_q == SYNC_LAST) begin
                            state_q <= ST_GAP;
                            cnt_q   <= '0;
                            dfm_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_GAP: begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    ST_DATA: begin
                        if (cnt_q == HIGH_LAST)
                            dclk_q <= 1'b0;
                        if (cnt_q == BIT_LAST) begin
                            // Last cycle of the segment's final bit.
                            cnt_q <= '0;
                            bit_q <= '0;
                            if (seg_q == FRM_LAST) begin
                                seg_q <= '0;
                                dat_q <= 1'b0;
                                if (iEn) begin
                                    state_q  <= ST_SYNC;
                                    dfm_q    <= 1'b1;
                                    fstart_q <= 1'b1;
                                end else begin
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                    shift_q <= '0;
                                    wbits_q <= '0;
                                end
                            end else begin
                                seg_q   <= seg_q + SEG_W'(1);
                                state_q <= ST_GAP;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // oReady is a decode of registered state so iValid/iData are sampled in the strobe cycle itself.
    assign oReady      = load;
    assign oDCLK       = dclk_q;
    assign oDFM        = dfm_q;
    assign oDAT        = dat_q;
    assign oUnderrun   = underrun_q;
    assign oFrameStart = fstart_q;
    assign oBusy       = busy_q;

endmodule

// File: tb/tb_dtfm_tx.sv
// tb_dtfm_tx: directed bench for dtfm_tx. Instance a: two 24-bit segments; instance b: one 10-bit segment.
module tb_dtfm_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  en, vld;
    logic [11:0] dat_in [2];
    logic [1:0]  rdy, dclk, dfm, dat, unr, fs, busy;

    dtfm_tx #(.CLK_DIV(2), .SYNC_CYC(4), .GAP_CYC(8), .SEG_BITS(24), .SEGS(2)) u_a (
        .clk(clk), .rst(rst), .iEn(en[0]), .iData(dat_in[0]), .iValid(vld[0]),
        .oReady(rdy[0]), .oDCLK(dclk[0]), .oDFM(dfm[0]), .oDAT(dat[0]),
        .oUnderrun(unr[0]), .oFrameStart(fs[0]), .oBusy(busy[0])
    );

    dtfm_tx #(.CLK_DIV(2), .SYNC_CYC(4), .GAP_CYC(8), .SEG_BITS(10), .SEGS(1)) u_b (
        .clk(clk), .rst(rst), .iEn(en[1]), .iData(dat_in[1]), .iValid(vld[1]),
        .oReady(rdy[1]), .oDCLK(dclk[1]), .oDFM(dfm[1]), .oDAT(dat[1]),
        .oUnderrun(unr[1]), .oFrameStart(fs[1]), .oBusy(busy[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-run observations; cycle 0 is the first SYNC cycle.
    logic [11:0] words [4];
    logic [3:0]  vmask;
    logic [63:0] rx;
    int          nbits, nrise, nrdy, nunr, unr_c, nfs, fs2_c, ndfm, end_c;
    int          rise_c [64];
    int          rdy_c  [8];

    task automatic run(input int s, input int en_off, input int rst_cyc);
        logic pd;
        pd = 1'b0; rx = '0; nbits = 0; nrise = 0; nrdy = 0; nunr = 0; unr_c = -1;
        nfs = 0; fs2_c = -1; ndfm = 0; end_c = -1;
        for (int c = 0; c < 600; c++) begin
            vld[s] = 1'b0;
            en[s]  = (c < en_off);
            if (c == rst_cyc) begin
                check("rst_dclk_high", dclk[s], 1'b1);
                rst = 1'b1;
                step();
                check("rst_outs_zero", {rdy[s], dclk[s], dfm[s], dat[s], unr[s], fs[s], busy[s]}, 7'b0);
                rst = 1'b0;
                return;
            end
            if (c > 0 && busy[s] == 1'b0) begin
                end_c = c;
                return;
            end
            if (dfm[s]) ndfm++;
            if (fs[s]) begin nfs++; if (c > 0) fs2_c = c; end
            if (unr[s]) begin nunr++; unr_c = c; end
            if (dclk[s] && !pd) begin
                if (nrise < 64) rise_c[nrise] = c;
                nrise++;
            end
            if (!dclk[s] && pd) begin
                rx = {rx[62:0], dat[s]};
                nbits++;
            end
            pd = dclk[s];
            if (rdy[s]) begin
                if (nrdy < 8) rdy_c[nrdy] = c;
                if (nrdy < 4) begin
                    vld[s]    = vmask[nrdy];
                    dat_in[s] = words[nrdy];
                end
                nrdy++;
            end
            step();
        end
    endtask

    task automatic start(input int s);
        en[s] = 1'b1;
        step();
    endtask

    initial begin
        int hits;
        rst = 1'b1; en = '0; vld = '0; dat_in[0] = '0; dat_in[1] = '0;

        // Reset and idle.
        repeat (3) step();
        check("reset_outs_a", {rdy[0], dclk[0], dfm[0], dat[0], unr[0], fs[0], busy[0]}, 7'b0);
        check("reset_outs_b", {rdy[1], dclk[1], dfm[1], dat[1], unr[1], fs[1], busy[1]}, 7'b0);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (rdy != 2'b00 || dfm != 2'b00 || busy != 2'b00 || dclk != 2'b00) hits++;
        end
        check("idle_quiet", hits, 0);

        // Single frame, all words valid.
        words[0] = 12'hA5C; words[1] = 12'h3F0; words[2] = 12'hFFF; words[3] = 12'h001;
        vmask = 4'b1111;
        start(0);
        run(0, 0, -1);
        check("frm_dfm_cycles", ndfm, 4);
        check("frm_fs_count", nfs, 1);
        check("frm_ready_count", nrdy, 4);
        check("frm_ready0", rdy_c[0], 11);
        check("frm_ready1", rdy_c[1], 59);
        check("frm_ready2_gap", rdy_c[2], 115);
        check("frm_ready3", rdy_c[3], 163);
        check("frm_bits", nbits, 48);
        check("frm_dclk_pulses", nrise, 48);
        check("frm_first_rise", rise_c[0], 12);
        check("frm_seg1_last_rise", rise_c[23], 104);
        check("frm_seg2_first_rise", rise_c[24], 116);
        check("frm_data", rx[47:0], 48'hA5C3F0FFF001);
        check("frm_no_underrun", nunr, 0);
        check("frm_end_idle", end_c, 212);

        // Underrun on the second strobe.
        vmask = 4'b1101;
        start(0);
        run(0, 0, -1);
        check("unr_count", nunr, 1);
        check("unr_cycle", unr_c, 60);
        check("unr_data", rx[47:0], 48'hA5C000FFF001);
        check("unr_ready_count", nrdy, 4);
        check("unr_end_idle", end_c, 212);

        // Reset while dCLK is high in segment 2, then a full restart.
        vmask = 4'b1111;
        start(0);
        run(0, 0, 120);
        start(0);
        check("rst_restart_sync", {fs[0], dfm[0]}, 2'b11);
        run(0, 0, -1);
        check("rst_restart_data", rx[47:0], 48'hA5C3F0FFF001);
        check("rst_restart_ready0", rdy_c[0], 11);
        check("rst_restart_end", end_c, 212);

        // Straddle across back-to-back frames; iEn drops during frame 2.
        words[0] = 12'hABC; words[1] = 12'h5A5; vmask = 4'b1111;
        start(1);
        run(1, 60, -1);
        check("str_fs_count", nfs, 2);
        check("str_fs2_cycle", fs2_c, 52);
        check("str_ready_count", nrdy, 2);
        check("str_ready0", rdy_c[0], 11);
        check("str_ready1", rdy_c[1], 71);
        check("str_bits", nbits, 20);
        check("str_data", rx[19:0], 20'hABC5A);
        check("str_end_idle", end_c, 104);

        // After IDLE the residue is gone: a fresh word is fetched before the first bit.
        words[0] = 12'h123;
        start(1);
        run(1, 0, -1);
        check("fresh_ready_count", nrdy, 1);
        check("fresh_ready0", rdy_c[0], 11);
        check("fresh_data", rx[9:0], 10'h048);
        check("fresh_end_idle", end_c, 52);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
